// File: rtl/traffic_pkg.sv
// Shared constants for the intersection phase scheduler: lamp codes,
// approach indices and FSM state encoding.
package traffic_pkg;

    localparam logic [1:0] LT_RED = 2'b00;
    localparam logic [1:0] LT_YEL = 2'b01;
    localparam logic [1:0] LT_GRN = 2'b10;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;
    localparam logic [1:0] ST_ALLRED = 2'd3;

endpackage

// File: rtl/rr_dir_picker.sv
// Rotating-priority picker: returns the first requesting approach found
// when scanning ptr, ptr+1, ... modulo 4.
module rr_dir_picker (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Scan the four positions starting at ptr; the first hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Round-robin phase scheduler for a four-approach intersection.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | all red, nothing requesting
//   ST_GREEN  | cur_dir green; timer counts green cycles (saturating)
//   ST_YELLOW | cur_dir yellow; timer counts yellow cycles
//   ST_ALLRED | clearance, all red; then pick the next approach
//
// Every output is registered from the next-state values so lamps, grant
// and preempt_active change on the same edge as the state register.
// grant is one-hot for the approach whose lamp is non-red.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_MAX  = 20,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nss,
    input  logic       ews,
    input  logic       sns,
    input  logic       wes,
    input  logic       emg_req,
    input  logic [1:0] emg_dir,
    output logic [1:0] n,
    output logic [1:0] e,
    output logic [1:0] s,
    output logic [1:0] w,
    output logic [3:0] grant,
    output logic       preempt_active
);

    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_CYC - 1);

    logic [1:0]       state, st_nx;
    logic [1:0]       cur_dir, dir_nx;
    logic [1:0]       rr_ptr, rr_nx;
    logic [CNT_W-1:0] timer, timer_nx;
    logic             pre_nx;
    logic             do_pick;
    logic [3:0]       req;
    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic             others;
    logic             own;
    logic [1:0]       lamp_nx;
    logic [3:0]       active_nx;

    assign req    = {wes, sns, ews, nss};
    assign others = |(req & ~(4'b0001 << cur_dir));
    assign own    = req[cur_dir];

    rr_dir_picker u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state, timer and round-robin pointer; emergency beats rotation.
    always_comb begin
        st_nx    = state;
        dir_nx   = cur_dir;
        rr_nx    = rr_ptr;
        timer_nx = timer;
        do_pick  = 1'b0;
        case (state)
            ST_IDLE: do_pick = 1'b1;
            ST_GREEN: begin
                if (emg_req) begin
                    if (emg_dir == cur_dir) begin
                        // Hold green; on release the exit rules resume as if
                        // the minimum green has just been reached.
                        timer_nx = T_GMIN;
                    end else begin
                        st_nx    = ST_YELLOW;
                        timer_nx = '0;
                    end
                end else if (timer >= T_GMIN && others && (!own || timer == T_GMAX)) begin
                    st_nx    = ST_YELLOW;
                    timer_nx = '0;
                end else if (timer < T_GMAX) begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_YELLOW: begin
                if (timer == T_YEL) begin
                    st_nx    = ST_ALLRED;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: begin
                if (timer == T_AR) do_pick = 1'b1;
                else               timer_nx = timer + 1'b1;
            end
        endcase

        if (do_pick) begin
            timer_nx = '0;
            if (emg_req) begin
                st_nx  = ST_GREEN;
                dir_nx = emg_dir;
            end else if (pick_valid) begin
                st_nx  = ST_GREEN;
                dir_nx = pick_idx;
                rr_nx  = pick_idx + 2'd1;
            end else begin
                st_nx  = ST_IDLE;
            end
        end

        pre_nx    = (st_nx == ST_GREEN) && emg_req && (dir_nx == emg_dir);
        lamp_nx   = (st_nx == ST_GREEN) ? LT_GRN : ((st_nx == ST_YELLOW) ? LT_YEL : LT_RED);
        active_nx = (st_nx == ST_GREEN || st_nx == ST_YELLOW) ? (4'b0001 << dir_nx) : 4'b0000;
    end

    // State and registered lamp/grant outputs; reset drops straight to all red.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cur_dir        <= DIR_N;
            rr_ptr         <= DIR_N;
            timer          <= '0;
            n              <= LT_RED;
            e              <= LT_RED;
            s              <= LT_RED;
            w              <= LT_RED;
            grant          <= 4'b0000;
            preempt_active <= 1'b0;
        end else begin
            state          <= st_nx;
            cur_dir        <= dir_nx;
            rr_ptr         <= rr_nx;
            timer          <= timer_nx;
            n              <= active_nx[DIR_N] ? lamp_nx : LT_RED;
            e              <= active_nx[DIR_E] ? lamp_nx : LT_RED;
            s              <= active_nx[DIR_S] ? lamp_nx : LT_RED;
            w              <= active_nx[DIR_W] ? lamp_nx : LT_RED;
            grant          <= active_nx;
            preempt_active <= pre_nx;
        end
    end

endmodule
